// File: rtl/binary_to_bcd_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD converter.
package binary_to_bcd_pkg;

  localparam int unsigned DATA_W = 30;
  localparam int unsigned DIGITS = 9;
  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = 5;

  localparam logic [DATA_W-1:0] SAT_MAX = 30'd999_999_999;
  localparam logic [BCD_W-1:0]  SAT_BCD = 36'h999999999;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble add-3 cell: one BCD digit, corrected before each shift.
module bcd_digit_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/binary_to_bcd.sv
// Free-running sequential double-dabble converter: 30-bit binary to 9 BCD digits,
// one bit per clock, 32-cycle period, registered and saturating output.
module binary_to_bcd
  import binary_to_bcd_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] data,
  output logic [BCD_W-1:0]  bcd_data
);

  state_t             r_state;
  logic [DATA_W-1:0]  r_shift;
  logic [BCD_W-1:0]   r_acc;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sat;
  logic [BCD_W-1:0]   w_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= ST_LOAD;
      r_shift <= '0;
      r_acc   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_shift <= data;
          r_sat   <= (data > SAT_MAX);
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // Carry out of the top digit (w_adj MSB) is dropped on purpose.
          {r_acc, r_shift} <= {w_adj[BCD_W-2:0], r_shift, 1'b0};
          r_cnt            <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1))
            r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_bcd   <= r_sat ? SAT_BCD : r_acc;
          r_state <= ST_LOAD;
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign bcd_data = r_bcd;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd against an arithmetic decimal-expansion model.
module tb_binary_to_bcd;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [29:0] data;
  logic [35:0] bcd_data;

  int checks;
  int failures;

  binary_to_bcd dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .data      (data),
    .bcd_data  (bcd_data)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [35:0] ref_bcd(input longint unsigned v);
    logic [35:0] r;
    longint unsigned x;
    x = (v > 64'd999999999) ? 64'd999999999 : v;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit nibbles_ok(input logic [35:0] b);
    for (int i = 0; i < 9; i++)
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Reset with value v applied; the first rising edge after release is the LOAD edge.
  task automatic restart(input logic [29:0] v);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    data      = v;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b1;
    data      = 30'd12345;
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (bcd_data !== 36'h0) begin
      failures++;
      $display("FAIL reset_value got=%h exp=%h", bcd_data, 36'h0);
    end
  endtask

  task automatic test_latency;
    logic [35:0] exp;
    exp = 36'h012345678;
    restart(30'd12345678);
    edges(31);
    checks++;
    if (bcd_data !== 36'h0) begin
      failures++;
      $display("FAIL latency_early got=%h exp=%h", bcd_data, 36'h0);
    end
    edges(1);
    checks++;
    if (bcd_data !== exp) begin
      failures++;
      $display("FAIL latency_first_done got=%h exp=%h", bcd_data, exp);
    end
    for (int i = 0; i < 31; i++) begin
      edges(1);
      checks++;
      if (bcd_data !== exp) begin
        failures++;
        $display("FAIL latency_hold cyc=%0d got=%h exp=%h", i, bcd_data, exp);
      end
    end
  endtask

  task automatic test_values;
    logic [29:0] vals [8];
    logic [35:0] exps [8];
    vals = '{30'd999999999, 30'd1000000000, 30'h3FFFFFFF, 30'd0,
             30'd9, 30'd10, 30'd12345, 30'd1};
    exps = '{36'h999999999, 36'h999999999, 36'h999999999, 36'h000000000,
             36'h000000009, 36'h000000010, 36'h000012345, 36'h000000001};
    for (int i = 0; i < 8; i++) begin
      restart(vals[i]);
      edges(32);
      checks++;
      if (bcd_data !== exps[i]) begin
        failures++;
        $display("FAIL value in=%0d got=%h exp=%h", vals[i], bcd_data, exps[i]);
      end
      checks++;
      if (!nibbles_ok(bcd_data)) begin
        failures++;
        $display("FAIL nibble_range in=%0d got=%h exp=all_digits_le_9", vals[i], bcd_data);
      end
    end
  endtask

  task automatic test_midshift_change;
    restart(30'd500);
    edges(10);
    data = 30'd777;
    edges(22);
    checks++;
    if (bcd_data !== 36'h000000500) begin
      failures++;
      $display("FAIL midshift_current got=%h exp=%h", bcd_data, 36'h000000500);
    end
    edges(32);
    checks++;
    if (bcd_data !== 36'h000000777) begin
      failures++;
      $display("FAIL midshift_next got=%h exp=%h", bcd_data, 36'h000000777);
    end
  endtask

  task automatic test_reset_mid_conversion;
    restart(30'd12345);
    edges(40);
    checks++;
    if (bcd_data !== 36'h000012345) begin
      failures++;
      $display("FAIL rstmid_pre got=%h exp=%h", bcd_data, 36'h000012345);
    end
    #3 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (bcd_data !== 36'h0) begin
      failures++;
      $display("FAIL rstmid_async got=%h exp=%h", bcd_data, 36'h0);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    edges(31);
    checks++;
    if (bcd_data !== 36'h0) begin
      failures++;
      $display("FAIL rstmid_not_retained got=%h exp=%h", bcd_data, 36'h0);
    end
    edges(1);
    checks++;
    if (bcd_data !== 36'h000012345) begin
      failures++;
      $display("FAIL rstmid_restart got=%h exp=%h", bcd_data, 36'h000012345);
    end
  endtask

  task automatic test_random;
    logic [29:0] v;
    logic [35:0] exp;
    for (int n = 0; n < 500; n++) begin
      @(negedge sys_clk);
      v    = 30'($urandom);
      if (n % 8 == 0) v = 30'($urandom_range(999999999, 0));
      data = v;
      exp  = ref_bcd(longint'(v));
      edges(64);
      checks++;
      if (bcd_data !== exp || !nibbles_ok(bcd_data)) begin
        failures++;
        $display("FAIL random in=%0d got=%h exp=%h", v, bcd_data, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset;
    test_latency;
    test_values;
    test_midshift_change;
    test_reset_mid_conversion;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
